// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor with valid/ready
// handshaking. Each stage adds one WIDTH/STAGES-bit chunk as 4-bit CLA groups,
// passing its carry, the finished low sum bits and the untouched operand bits
// to the next stage. WIDTH must be a multiple of 4*STAGES.
module cla_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;  // bits added per stage
  localparam int NG = CW / 4;          // 4-bit lookahead groups per stage

  // One 4-bit carry-lookahead group: returns {group_g, group_p, sum[3:0]}.
  // Internal carries are expressed directly from the group carry-in.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       gp;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
    return {gg, gp, p ^ c};
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;

  // Per-stage inputs: index k is what stage k consumes. Index 0 comes from the
  // ports (with subtraction folded into ~b and a forced carry-in of 1).
  logic [STAGES-1:0][WIDTH-1:0] fwd_a;
  logic [STAGES-1:0][WIDTH-1:0] fwd_b;
  logic [STAGES-1:0][WIDTH-1:0] fwd_s;
  logic [STAGES-1:0]            fwd_c;

  assign fwd_a[0] = a;
  assign fwd_b[0] = sub ? ~b : b;
  assign fwd_s[0] = '0;
  assign fwd_c[0] = sub ? 1'b1 : cin;

  // Advance chain: a stage moves when empty or when its successor moves.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  assign in_ready  = !valid_q[0] || adv[0];
  assign out_valid = valid_q[STAGES-1];

  // Valid bits shift forward only where the stage advances.
  always_comb begin
    valid_d = valid_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  // Valid register; reset empties the whole pipe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] s_q;
      logic [WIDTH-1:0] s_d;
      logic             c_q;
      logic             c_d;
      logic             carry;
      logic [5:0]       grp;

      // Add this stage's chunk group by group; hold everything while stalled.
      always_comb begin
        s_d   = s_q;
        c_d   = c_q;
        carry = fwd_c[gi];
        grp   = '0;
        if (adv[gi]) begin
          s_d = fwd_s[gi];
          for (int j = 0; j < NG; j++) begin
            grp = cla4(fwd_a[gi][gi*CW + j*4 +: 4], fwd_b[gi][gi*CW + j*4 +: 4], carry);
            s_d[gi*CW + j*4 +: 4] = grp[3:0];
            carry = grp[5] | (grp[4] & carry);
          end
          c_d = carry;
        end
      end

      // Partial sum and chunk carry-out registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q <= '0;
          c_q <= 1'b0;
        end else begin
          s_q <= s_d;
          c_q <= c_d;
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] b_d;

        // Operands ride along so later stages see their chunks and the signs.
        always_comb begin
          a_d = a_q;
          b_d = b_q;
          if (adv[gi]) begin
            a_d = fwd_a[gi];
            b_d = fwd_b[gi];
          end
        end

        // Delayed operand registers.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_q <= '0;
            b_q <= '0;
          end else begin
            a_q <= a_d;
            b_q <= b_d;
          end
        end

        assign fwd_a[gi+1] = a_q;
        assign fwd_b[gi+1] = b_q;
        assign fwd_s[gi+1] = s_q;
        assign fwd_c[gi+1] = c_q;
      end else begin : g_last
        logic ovf_q;
        logic ovf_d;
        logic zero_q;
        logic zero_d;

        // Flags are formed alongside the final chunk so they stay aligned.
        always_comb begin
          ovf_d  = ovf_q;
          zero_d = zero_q;
          if (adv[gi]) begin
            ovf_d  = (fwd_a[gi][WIDTH-1] == fwd_b[gi][WIDTH-1]) &&
                     (s_d[WIDTH-1] != fwd_a[gi][WIDTH-1]);
            zero_d = (s_d == '0);
          end
        end

        // Overflow and zero flag registers.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
          end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
          end
        end

        assign sum  = s_q;
        assign cout = c_q;
        assign ovf  = ovf_q;
        assign zero = zero_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_pipe.sv
// Directed and handshake checks for cla_pipe (16-bit/4-stage and 8-bit/1-stage).
module tb_cla_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;

  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;

  cla_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  cla_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {sum, cout, ovf, zero}.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] be;
    logic [16:0] t;
    logic        o;
    be = ms ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, be} + {16'd0, (ms ? 1'b1 : mc)};
    o  = (ma[15] == be[15]) && (t[15] != ma[15]);
    return {t[15:0], t[16], o, (t[15:0] == 16'd0)};
  endfunction

  logic [18:0] exp_q[$];
  logic [18:0] held, front;
  logic        stall_prev;
  int          occ, sent, consumed, emits, n;
  logic [15:0] ra, rb, last_sum;
  logic        rc, rs, acc, need_new;

  // One handshake cycle: drive at negedge, sample 1ns later, update scoreboard.
  task automatic run_cycle(input logic dv, input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tc, input logic ts, input logic tr,
                           output logic accepted);
    @(negedge clk);
    in_valid = dv; a = ta; b = tb_; cin = tc; sub = ts; out_ready = tr;
    #1;
    if (stall_prev) check("stall_hold", {13'd0, sum, cout, ovf, zero}, {13'd0, held});
    check("in_ready_rule", in_ready, !(occ == 4 && !out_ready));
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        front = exp_q.pop_front();
        check("rand_result", {13'd0, sum, cout, ovf, zero}, {13'd0, front});
      end
      consumed++;
      occ--;
    end
    if (accepted) begin
      exp_q.push_back(model(ta, tb_, tc, ts));
      occ++;
    end
    stall_prev = out_valid && !out_ready;
    held = {sum, cout, ovf, zero};
  endtask

  // Single operation into an idle pipe; checks latency and all result fields.
  task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
    int k;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts; out_ready = 1'b1;
    #1 check({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_lat"}, k, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_zero"}, zero, ez);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 1;
    stall_prev = 0; occ = 0; sent = 0; consumed = 0; held = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ovf, zero}, 3'b000);
    check("rst_out_valid8", out_valid8, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic, hand-computed results
    directed("add_carry8",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    directed("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("add_cin_wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_borrow",  16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    directed("sub_equal",   16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Back-to-back random operations with random backpressure
    need_new = 1'b1;
    ra = 0; rb = 0; rc = 0; rs = 0;
    for (int cyc = 0; cyc < 400 && consumed < 16; cyc++) begin
      if (sent < 16 && need_new) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
        need_new = 1'b0;
      end
      run_cycle(sent < 16, ra, rb, rc, rs, 1'($urandom), acc);
      if (acc) begin
        sent++;
        need_new = 1'b1;
      end
    end
    check("rand_sent", sent, 16);
    check("rand_consumed", consumed, 16);
    check("rand_queue_empty", exp_q.size(), 0);

    // Reset in the middle of traffic
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 0; sub = 0;
    @(negedge clk);
    a = 16'h0101; b = 16'h0202;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rstmid_pre_valid", out_valid, 1);
    check("rstmid_pre_sum", sum, 16'h3333);
    #2 rst = 1'b1;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_sum", sum, 0);
    check("rstmid_flags", {cout, ovf, zero}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; out_ready = 1'b1;
    #1 check("post_rst_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    emits = 0; last_sum = 0;
    repeat (12) begin
      #1;
      if (out_valid) begin
        emits++;
        last_sum = sum;
      end
      @(negedge clk);
    end
    check("post_rst_emits", emits, 1);
    check("post_rst_sum", last_sum, 16'h2345);

    // 8-bit single-stage instance
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 0; sub8 = 0; out_ready8 = 1'b1;
    #1 check("w8_rdy", in_ready8, 1);
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    check("w8_valid", out_valid8, 1);
    check("w8_sum", sum8, 8'h00);
    check("w8_cout", cout8, 1);
    check("w8_zero", zero8, 1);
    check("w8_ovf", ovf8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a multiple of 4*STAGES.
REQ-002 Parameter STAGES, default 4: pipeline depth; legal values 1, 2 or 4; each stage adds WIDTH/STAGES bits.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port in_valid  input  1: the upstream source presents an operation.
REQ-006 Port in_ready  output  1: the block accepts an operation on this cycle.
REQ-007 Port a  input  WIDTH: first operand.
REQ-008 Port b  input  WIDTH: second operand.
REQ-009 Port cin  input  1: carry-in; used only when sub=0.
REQ-010 Port sub  input  1: mode select; 0 = a+b+cin, 1 = a-b.
REQ-011 Port out_valid  output  1: a result is presented.
REQ-012 Port out_ready  input  1: the downstream sink accepts the result.
REQ-013 Port sum  output  WIDTH: result, modulo 2^WIDTH.
REQ-014 Port cout  output  1: carry out of the MSB.
REQ-015 Port ovf  output  1: two's-complement signed overflow.
REQ-016 Port zero  output  1: sum equals 0.

Function
REQ-017 Transfer rule: input is accepted when in_valid && in_ready; output is consumed when out_valid && out_ready.
REQ-018 Arithmetic: sub=0 computes a + b + cin; sub=1 computes a + ~b + 1 and ignores cin.
REQ-019 Stage k (k = 0..STAGES-1) SHALL add chunk bits [k*W/S +: W/S] as 4-bit carry-lookahead groups with group generate/propagate, taking carry-in from stage k-1's registered carry.
REQ-020 Chunks above the current stage SHALL travel with the operation as delayed operands; completed low sum bits SHALL travel forward with the operation.
REQ-021 Each stage SHALL hold a valid bit; stage k SHALL advance when it is empty or its successor advances; the last stage SHALL advance when out_ready is high or out_valid is low.
REQ-022 Bubble collapse: in_ready = !valid[0] || advance[0]; in_ready SHALL depend combinationally on out_ready.
REQ-023 Latency: an accepted operation SHALL appear on the outputs exactly STAGES cycles later when there is no stall; full throughput SHALL be 1 operation per cycle.
REQ-024 Stall: while out_valid && !out_ready, sum, cout, ovf and zero SHALL hold stable; no operation SHALL be dropped, duplicated or reordered.
REQ-025 cout = carry out of bit WIDTH-1, from the effective operands (~b when sub=1).
REQ-026 ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]); the MSB signs SHALL be carried through the pipeline.
REQ-027 zero SHALL be registered with the final stage, not derived combinationally from a later cycle's state.

Reset
REQ-028 rst high SHALL clear all stage valid bits immediately; out_valid SHALL be 0 and in_ready SHALL be 1 while rst is high.
REQ-029 On reset, sum, cout, ovf and zero SHALL be 0, and all pipeline data registers SHALL be 0.
REQ-030 Reset mid-operation SHALL discard in-flight operations; none SHALL emerge after reset release.
REQ-031 Input accepted in the first cycle after rst deasserts SHALL be processed normally.

Verification (WIDTH=16, STAGES=4 unless noted)
REQ-032 0x00FF+0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0100, cout=0, ovf=0, zero=0.
REQ-033 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1, zero=1.
REQ-034 sub: 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovf=0; 0x0005-0x0005 -> sum=0x0000, cout=1, zero=1; 0x8000-0x0001 -> sum=0x7FFF, ovf=1.
REQ-035 16 back-to-back random operations with out_ready toggled pseudo-randomly -> results in order, each exactly once, outputs stable during stalls, in_ready low only when the pipe is full and stalled.
REQ-036 Accept 2 operations, then assert rst asynchronously mid-cycle -> out_valid=0 at once, all outputs 0, neither operation ever emitted after release.
REQ-037 WIDTH=8, STAGES=1: 0xFF+0x01 -> next cycle sum=0x00, cout=1, zero=1, ovf=0.
